// File: rtl/corescore_pkg.sv
// Shared definitions for the CLKOUT0 reconfiguration controller: FSM states,
// ClkReg addresses/masks and the read-modify-write merge.
package corescore_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RST_ASSERT,
    RD,
    RD_WAIT,
    WR,
    WR_WAIT,
    LOCK_WAIT,
    DONE,
    ERR
  } drp_state_e;

  localparam logic [6:0]  CLKREG1_ADDR = 7'h08;
  localparam logic [6:0]  CLKREG2_ADDR = 7'h09;
  localparam logic [15:0] CLKREG1_KEEP = 16'hF000;
  localparam logic [15:0] CLKREG2_KEEP = 16'hFF3F;

  function automatic logic [6:0] clkreg_addr(input logic idx);
    return idx ? CLKREG2_ADDR : CLKREG1_ADDR;
  endfunction

  // High time is ceil(D/2), i.e. floor(D/2) + D[0], which fits in 6 bits for D <= 126.
  function automatic logic [15:0] clkreg_merge(input logic        idx,
                                               input logic [15:0] rd,
                                               input logic [6:0]  div);
    logic [5:0] lo;
    logic [5:0] hi;
    lo = div[6:1];
    hi = div[6:1] + {5'b0, div[0]};
    if (!idx)
      return (rd & CLKREG1_KEEP) | {4'b0, hi, lo};
    else
      return (rd & CLKREG2_KEEP) | {8'b0, div[0], 7'b0};
  endfunction

endpackage

// File: rtl/corescore_sync2.sv
// Two-flop synchroniser for a single asynchronous level input.
module corescore_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta <= 1'b0;
      o_q  <= 1'b0;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/corescore_mmcm_drp_ctrl.sv
// Reprograms the MMCM CLKOUT0 divider over DRP (read-modify-write of ClkReg1/2),
// holds the MMCM in reset meanwhile and gates downstream reset on lock.
module corescore_mmcm_drp_ctrl
  import corescore_pkg::*;
#(
  parameter int unsigned DRDY_TIMEOUT = 64,
  parameter int unsigned LOCK_TIMEOUT = 65536
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic [6:0]  i_div,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [6:0]  o_drp_addr,
  output logic        o_drp_en,
  output logic        o_drp_we,
  output logic [15:0] o_drp_di,
  input  logic [15:0] i_drp_do,
  input  logic        i_drp_rdy,
  output logic        o_mmcm_rst,
  input  logic        i_locked,
  output logic        o_rst
);

  localparam int unsigned DW = $clog2(DRDY_TIMEOUT + 1);
  localparam int unsigned LW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [DW-1:0] DRDY_LAST = DW'(DRDY_TIMEOUT - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_TIMEOUT - 1);

  drp_state_e    state;
  logic [6:0]    div_q;
  logic          idx;
  logic [DW-1:0] wait_cnt;
  logic [LW-1:0] lock_cnt;
  logic          locked_s;
  logic          locked_d;
  logic          div_legal;

  corescore_sync2 u_lock_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_locked),
    .o_q   (locked_s)
  );

  assign div_legal = (i_div >= 7'd2) && (i_div <= 7'd126);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      div_q      <= '0;
      idx        <= 1'b0;
      wait_cnt   <= '0;
      lock_cnt   <= '0;
      locked_d   <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_drp_addr <= '0;
      o_drp_en   <= 1'b0;
      o_drp_we   <= 1'b0;
      o_drp_di   <= '0;
      o_mmcm_rst <= 1'b0;
      o_rst      <= 1'b1;
    end else begin
      o_drp_en <= 1'b0;
      o_drp_we <= 1'b0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
      locked_d <= locked_s;
      // Fabric reset releases only when idle with lock stable for two cycles.
      o_rst    <= !(state == IDLE && !o_busy && locked_s && locked_d);

      unique case (state)
        IDLE: begin
          if (i_req) begin
            if (div_legal) begin
              div_q      <= i_div;
              idx        <= 1'b0;
              o_busy     <= 1'b1;
              o_mmcm_rst <= 1'b1;
              o_rst      <= 1'b1;
              state      <= RST_ASSERT;
            end else begin
              o_err <= 1'b1;
            end
          end
        end

        RST_ASSERT: begin
          o_drp_en   <= 1'b1;
          o_drp_addr <= clkreg_addr(idx);
          state      <= RD;
        end

        RD: begin
          wait_cnt <= '0;
          state    <= RD_WAIT;
        end

        RD_WAIT: begin
          if (i_drp_rdy) begin
            o_drp_en <= 1'b1;
            o_drp_we <= 1'b1;
            o_drp_di <= clkreg_merge(idx, i_drp_do, div_q);
            state    <= WR;
          end else if (wait_cnt == DRDY_LAST) begin
            o_err      <= 1'b1;
            o_mmcm_rst <= 1'b0;
            state      <= ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        WR: begin
          wait_cnt <= '0;
          state    <= WR_WAIT;
        end

        WR_WAIT: begin
          if (i_drp_rdy) begin
            if (!idx) begin
              idx        <= 1'b1;
              o_drp_en   <= 1'b1;
              o_drp_addr <= clkreg_addr(1'b1);
              state      <= RD;
            end else begin
              o_mmcm_rst <= 1'b0;
              lock_cnt   <= '0;
              state      <= LOCK_WAIT;
            end
          end else if (wait_cnt == DRDY_LAST) begin
            o_err      <= 1'b1;
            o_mmcm_rst <= 1'b0;
            state      <= ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        LOCK_WAIT: begin
          if (locked_s) begin
            o_done <= 1'b1;
            state  <= DONE;
          end else if (lock_cnt == LOCK_LAST) begin
            o_err <= 1'b1;
            state <= ERR;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end

        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end

        ERR: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_corescore_mmcm_drp_ctrl.sv
// Directed bench for the CLKOUT0 DRP controller with a 3-cycle DRP model and a lock model.
module tb_corescore_mmcm_drp_ctrl;

  localparam int unsigned DRDY_TO = 16;
  localparam int unsigned LOCK_TO = 300;

  logic        clk = 1'b0;
  logic        i_rst, i_req;
  logic [6:0]  i_div;
  logic        o_busy, o_done, o_err;
  logic [6:0]  o_drp_addr;
  logic        o_drp_en, o_drp_we;
  logic [15:0] o_drp_di;
  logic [15:0] i_drp_do;
  logic        i_drp_rdy;
  logic        o_mmcm_rst;
  logic        i_locked;
  logic        o_rst;

  int n_checks = 0;
  int n_pass   = 0;

  int          en_cnt = 0;
  int          wr_cnt = 0;
  int          pend;
  int          lcnt;
  logic        prev_en;
  logic        proto_bad = 1'b0;
  logic        rdy_ena   = 1'b1;
  logic        lock_ena  = 1'b1;
  logic [6:0]  last_addr = '0;
  logic [15:0] wr_data [2];

  int   n;
  logic got;

  always #5 clk = ~clk;

  corescore_mmcm_drp_ctrl #(
    .DRDY_TIMEOUT (DRDY_TO),
    .LOCK_TIMEOUT (LOCK_TO)
  ) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_req      (i_req),
    .i_div      (i_div),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err),
    .o_drp_addr (o_drp_addr),
    .o_drp_en   (o_drp_en),
    .o_drp_we   (o_drp_we),
    .o_drp_di   (o_drp_di),
    .i_drp_do   (i_drp_do),
    .i_drp_rdy  (i_drp_rdy),
    .o_mmcm_rst (o_mmcm_rst),
    .i_locked   (i_locked),
    .o_rst      (o_rst)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // DRP slave: rdy three cycles after each enable; reads 0xA5A5 at 0x08, 0x5A5A at 0x09.
  initial begin
    i_drp_rdy = 1'b0;
    i_drp_do  = '0;
    pend      = 0;
    prev_en   = 1'b0;
    wr_data[0] = '0;
    wr_data[1] = '0;
    forever begin
      @(posedge clk);
      #2;
      i_drp_rdy = 1'b0;
      if (i_rst) begin
        pend = 0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0 && rdy_ena) begin
          i_drp_rdy = 1'b1;
          i_drp_do  = (last_addr == 7'h08) ? 16'hA5A5 : 16'h5A5A;
        end
      end
      if (o_drp_en) begin
        if (prev_en || pend > 0) proto_bad = 1'b1;
        en_cnt++;
        last_addr = o_drp_addr;
        pend = 3;
        if (o_drp_we) begin
          wr_cnt++;
          if (o_drp_addr == 7'h08)      wr_data[0] = o_drp_di;
          else if (o_drp_addr == 7'h09) wr_data[1] = o_drp_di;
          else                          proto_bad = 1'b1;
        end
      end else if (o_drp_we) begin
        proto_bad = 1'b1;
      end
      prev_en = o_drp_en;
    end
  end

  // MMCM lock: drops while RST is high, returns 100 cycles after release.
  initial begin
    i_locked = 1'b1;
    lcnt     = 0;
    forever begin
      @(posedge clk);
      #2;
      if (o_mmcm_rst) begin
        i_locked = 1'b0;
        lcnt     = 0;
      end else if (!i_locked && lock_ena) begin
        lcnt++;
        if (lcnt >= 100) i_locked = 1'b1;
      end
    end
  end

  initial begin
    i_rst = 1'b1;
    i_req = 1'b0;
    i_div = '0;
    repeat (3) tick();
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    chk("rst_en", o_drp_en, 0);
    chk("rst_we", o_drp_we, 0);
    chk("rst_addr", o_drp_addr, 0);
    chk("rst_di", o_drp_di, 0);
    chk("rst_mmcm_rst", o_mmcm_rst, 0);
    chk("rst_o_rst", o_rst, 1);
    i_rst = 1'b0;
    repeat (6) tick();
    chk("idle_locked_o_rst", o_rst, 0);

    // Nominal D=75 with a second request injected mid-sequence
    en_cnt = 0; wr_cnt = 0;
    i_div = 7'd75; i_req = 1'b1;
    tick();
    i_req = 1'b0;
    chk("acc_busy", o_busy, 1);
    chk("acc_mmcm_rst", o_mmcm_rst, 1);
    chk("acc_o_rst", o_rst, 1);
    got = 1'b0;
    for (int i = 0; i < 600; i++) begin
      i_req = (i == 20);
      i_div = (i == 20) ? 7'd10 : 7'd75;
      tick();
      if (o_done) begin got = 1'b1; break; end
    end
    i_req = 1'b0;
    chk("d75_done_seen", got, 1);
    chk("d75_en_count", en_cnt, 4);
    chk("d75_wr_count", wr_cnt, 2);
    chk("d75_reg1", wr_data[0], 16'hA9A5);
    chk("d75_reg2", wr_data[1], 16'h5A9A);
    chk("d75_busy_in_done", o_busy, 1);
    chk("d75_o_rst_in_done", o_rst, 1);
    tick();
    chk("d75_done_pulse", o_done, 0);
    chk("d75_busy_clear", o_busy, 0);
    tick();
    chk("d75_o_rst_release", o_rst, 0);

    // Illegal divides
    en_cnt = 0;
    i_div = 7'd1; i_req = 1'b1;
    tick();
    i_req = 1'b0;
    chk("div1_err", o_err, 1);
    chk("div1_busy", o_busy, 0);
    chk("div1_mmcm_rst", o_mmcm_rst, 0);
    tick();
    chk("div1_err_pulse", o_err, 0);
    i_div = 7'd127; i_req = 1'b1;
    tick();
    i_req = 1'b0;
    chk("div127_err", o_err, 1);
    repeat (3) tick();
    chk("illegal_no_drp", en_cnt, 0);
    chk("illegal_busy", o_busy, 0);

    // Upper boundary D=126
    en_cnt = 0; wr_cnt = 0;
    i_div = 7'd126; i_req = 1'b1;
    tick();
    i_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (o_done) begin got = 1'b1; break; end
    end
    chk("d126_done_seen", got, 1);
    chk("d126_reg1", wr_data[0], 16'hAFFF);
    chk("d126_reg2", wr_data[1], 16'h5A1A);
    chk("d126_en_count", en_cnt, 4);
    repeat (4) tick();

    // DRDY timeout in RD_WAIT
    rdy_ena = 1'b0;
    i_div = 7'd75; i_req = 1'b1;
    tick();
    i_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_drp_en) begin got = 1'b1; break; end
      tick();
    end
    chk("to_rd_en_seen", got, 1);
    n = 0; got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      n++;
      if (o_err) begin got = 1'b1; break; end
    end
    chk("to_err_seen", got, 1);
    chk("to_err_latency", n, DRDY_TO + 1);
    chk("to_mmcm_rst", o_mmcm_rst, 0);
    chk("to_o_rst", o_rst, 1);
    tick();
    chk("to_err_pulse", o_err, 0);
    chk("to_busy_clear", o_busy, 0);
    chk("to_mmcm_rst_after", o_mmcm_rst, 0);
    rdy_ena = 1'b1;
    repeat (130) tick();

    // Lock timeout
    lock_ena = 1'b0;
    i_div = 7'd75; i_req = 1'b1;
    tick();
    i_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!o_mmcm_rst) begin got = 1'b1; break; end
    end
    chk("lk_mmcm_release", got, 1);
    n = 0; got = 1'b0;
    for (int i = 0; i < LOCK_TO + 50; i++) begin
      tick();
      n++;
      if (o_err) begin got = 1'b1; break; end
    end
    chk("lk_err_seen", got, 1);
    chk("lk_err_latency", n, LOCK_TO);
    chk("lk_o_rst_err", o_rst, 1);
    tick();
    chk("lk_busy_clear", o_busy, 0);
    repeat (5) tick();
    chk("lk_o_rst_held", o_rst, 1);
    lock_ena = 1'b1;
    repeat (130) tick();

    // Reset during WR_WAIT, then a fresh request D=3
    i_div = 7'd75; i_req = 1'b1;
    tick();
    i_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (o_drp_en && o_drp_we) begin got = 1'b1; break; end
      tick();
    end
    chk("mr_wr_seen", got, 1);
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("mr_busy", o_busy, 0);
    chk("mr_en", o_drp_en, 0);
    chk("mr_we", o_drp_we, 0);
    chk("mr_addr", o_drp_addr, 0);
    chk("mr_di", o_drp_di, 0);
    chk("mr_mmcm_rst", o_mmcm_rst, 0);
    chk("mr_o_rst", o_rst, 1);
    chk("mr_err", o_err, 0);
    repeat (5) tick();
    en_cnt = 0; wr_cnt = 0; proto_bad = 1'b0;
    i_div = 7'd3; i_req = 1'b1;
    tick();
    i_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (o_done) begin got = 1'b1; break; end
    end
    chk("d3_done_seen", got, 1);
    chk("d3_reg1", wr_data[0], 16'hA081);
    chk("d3_reg2", wr_data[1], 16'h5A9A);
    chk("d3_en_count", en_cnt, 4);
    chk("d3_protocol", proto_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/corescore_mmcm_drp_ctrl.md
CORESCORE_MMCM_DRP_CTRL -- requirements
Module: corescore_mmcm_drp_ctrl

Interface
REQ-001 SHALL have parameter DRDY_TIMEOUT, default 64, the maximum cycles to wait for i_drp_rdy per DRP access.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65536, the maximum cycles to wait for lock after the MMCM reset is released.
REQ-003 i_clk  in  1  single clock, the MMCM input clock domain; all logic is on posedge i_clk.
REQ-004 i_rst  in  1  reset; synchronous and active-high.
REQ-005 i_req  in  1  one-cycle pulse that starts reconfiguration of CLKOUT0.
REQ-006 i_div  in  7  requested CLKOUT0 divide value; legal range 2..126; sampled when i_req is accepted.
REQ-007 o_busy  out  1  high from accepted i_req until the DONE or ERR exit.
REQ-008 o_done  out  1  one-cycle pulse on successful completion.
REQ-009 o_err  out  1  one-cycle pulse on illegal divide, DRDY timeout or lock timeout.
REQ-010 o_drp_addr  out  7  MMCM DRP address.
REQ-011 o_drp_en  out  1  DRP enable, one-cycle pulse per access.
REQ-012 o_drp_we  out  1  DRP write enable, asserted only together with o_drp_en.
REQ-013 o_drp_di  out  16  DRP write data.
REQ-014 i_drp_do  in  16  DRP read data, valid when i_drp_rdy is high.
REQ-015 i_drp_rdy  in  1  DRP access complete.
REQ-016 o_mmcm_rst  out  1  drives MMCM RST.
REQ-017 i_locked  in  1  MMCM LOCKED; asynchronous to i_clk.
REQ-018 o_rst  out  1  active-high reset for downstream fabric logic.

Function
REQ-019 SHALL implement FSM states IDLE, RST_ASSERT, RD, RD_WAIT, WR, WR_WAIT, LOCK_WAIT, DONE, ERR.
REQ-020 SHALL, in IDLE when i_req=1 and 2<=i_div<=126: latch i_div, set o_busy, set o_mmcm_rst=1 and o_rst=1 next cycle, then enter RST_ASSERT.
REQ-021 SHALL, in IDLE when i_req=1 and i_div<2 or i_div=127: pulse o_err in the next cycle, make no DRP access, leave o_mmcm_rst unchanged and stay idle.
REQ-022 SHALL ignore i_req while o_busy=1; the request is neither queued nor reported as an error.
REQ-023 SHALL program registers in fixed order: index 0 at addr 0x08 (ClkReg1), then index 1 at addr 0x09 (ClkReg2); each register uses a 1-bit index counter.
REQ-024 SHALL perform each register as a read-modify-write:
- RD: pulse o_drp_en with o_drp_we=0.
- RD_WAIT: wait for i_drp_rdy.
- WR: pulse o_drp_en and o_drp_we with o_drp_di = (i_drp_do & KEEP_MASK) | new_bits.
- WR_WAIT: wait for i_drp_rdy.
REQ-025 SHALL use the read data captured on the i_drp_rdy cycle of RD_WAIT as the read value for the merge.
REQ-026 SHALL compute ClkReg1 as follows, with D the latched divide:
- LOW_TIME [5:0] = floor(D/2).
- HIGH_TIME [11:6] = D - floor(D/2).
- KEEP_MASK = 0xF000.
REQ-027 SHALL compute ClkReg2 as follows:
- EDGE bit7 = D[0].
- NO_COUNT bit6 = 0.
- KEEP_MASK = 0xFF3F.
REQ-028 SHALL count cycles in each *_WAIT state; when the count reaches DRDY_TIMEOUT without i_drp_rdy, it SHALL enter ERR.
REQ-029 SHALL, after WR_WAIT of index 1: deassert o_mmcm_rst, clear the lock timer and enter LOCK_WAIT.
REQ-030 SHALL synchronise i_locked through 2 flops before any use.
REQ-031 SHALL, in LOCK_WAIT, enter DONE once synced locked is high; it SHALL enter ERR if LOCK_TIMEOUT cycles elapse first.
REQ-032 SHALL, in DONE, pulse o_done for one cycle, clear o_busy and return to IDLE.
REQ-033 SHALL, in ERR, pulse o_err for one cycle, set o_mmcm_rst=0, clear o_busy and return to IDLE, keeping o_rst=1.
REQ-034 SHALL drive o_rst = 1 whenever o_busy=1 or synced locked=0.
REQ-035 SHALL deassert o_rst one cycle after synced locked has been high for 2 consecutive cycles while idle.
REQ-036 SHALL never assert o_drp_en on two consecutive cycles.
REQ-037 SHALL never issue a new DRP access before the previous access's i_drp_rdy.
REQ-038 SHALL ignore i_drp_rdy outside the *_WAIT states.

Reset
REQ-039 SHALL, while i_rst=1 at a clock edge, set: FSM=IDLE, o_busy=0, o_done=0, o_err=0, o_drp_en=0, o_drp_we=0, o_drp_addr=0, o_drp_di=0, o_mmcm_rst=0, o_rst=1, and clear the counters and synchroniser.
REQ-040 SHALL, when i_rst is asserted mid-sequence, abandon the DRP access without waiting for i_drp_rdy and release o_mmcm_rst in the next cycle.

Structure
REQ-041 SHALL take the following from the shared package corescore_pkg:
- FSM state enum.
- DRP addresses 0x08 and 0x09.
- KEEP masks 0xF000 and 0xFF3F.
REQ-042 SHALL instantiate one sub-module, corescore_sync2, the 2-flop synchroniser used for i_locked; all other logic SHALL be in a single module.

Verification
REQ-043 i_req with i_div=75, DRP model giving rdy 3 cycles after en and reading 0xA5A5/0x5A5A -> writes:
- 0x08: 0xA000 | (38<<6) | 37 = 0xA9A5.
- 0x09: 0x5A1A | 0x80 = 0x5A9A.
- Then lock after 100 cycles -> o_done pulse and o_rst falls.
REQ-044 i_div=1 -> o_err pulse one cycle after i_req; no o_drp_en; o_busy stays 0.
REQ-045 DRP model never returns rdy -> o_err exactly DRDY_TIMEOUT cycles into RD_WAIT; o_mmcm_rst=0 afterwards.
REQ-046 i_locked held low after writes -> o_err after LOCK_TIMEOUT cycles; o_rst stays 1.
REQ-047 i_req repeated during a busy sequence -> ignored; exactly 4 DRP accesses occur.
REQ-048 i_rst pulsed in WR_WAIT -> all outputs at their reset values next cycle; a new i_req then completes normally.
